// File: rtl/roulette_spin_sequencer.sv
// roulette_spin_sequencer: steps a lit pocket around the wheel, then
// decelerates and lands on a latched target pocket.
//
// Ports:
//   clock    in  1  rising-edge clock
//   reset    in  1  asynchronous active-low reset
//   start    in  1  spin request (level or pulse)
//   target   in  6  landing pocket, latched when start is accepted
//   abort    in  1  cancel a spin in progress
//   position out 6  lit pocket, feeds led_decoder
//   busy     out 1  spin in progress
//   done     out 1  one-cycle landing pulse
//   err      out 1  one-cycle pulse on start with out-of-range target
module roulette_spin_sequencer #(
  parameter int unsigned NUM_POS  = 38,
  parameter int unsigned BASE_DIV = 2500000,
  parameter int unsigned DIV_STEP = 250000,
  parameter int unsigned MAX_DIV  = 25000000,
  parameter int unsigned MIN_LAPS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] target,
  input  logic       abort,
  output logic [5:0] position,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPIN  = 2'd1,
    DECEL = 2'd2
  } state_t;

  localparam logic [31:0] BASE = 32'(BASE_DIV);
  localparam logic [31:0] STEP = 32'(DIV_STEP);
  localparam logic [31:0] MAXV = 32'(MAX_DIV);
  localparam logic [31:0] LAPS = 32'(MIN_LAPS);
  localparam logic [6:0]  NPOS = 7'(NUM_POS);
  localparam logic [5:0]  LAST = 6'(NUM_POS - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ivl_q, ivl_d;
  logic [31:0] laps_q, laps_d;
  logic [5:0]  pos_q, pos_d;
  logic [5:0]  tgt_q, tgt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        step;
  logic        wrap;
  logic [5:0]  pos_nxt;

  // 33-bit sum so the saturation test can never overflow.
  function automatic logic [31:0] sat_add(input logic [31:0] a);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, STEP};
    return (s > {1'b0, MAXV}) ? MAXV : s[31:0];
  endfunction

  assign step    = (cnt_q == ivl_q - 32'd1);
  assign wrap    = (pos_q == LAST);
  assign pos_nxt = wrap ? 6'd0 : pos_q + 6'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ivl_d   = ivl_q;
    laps_d  = laps_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, target} < NPOS) begin
            tgt_d   = target;
            ivl_d   = BASE;
            laps_d  = 32'd0;
            cnt_d   = 32'd0;
            state_d = SPIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SPIN: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          laps_d  = 32'd0;
          ivl_d   = BASE;
        end else if (step) begin
          cnt_d = 32'd0;
          pos_d = pos_nxt;
          if (wrap) begin
            laps_d = laps_q + 32'd1;
            if (laps_q + 32'd1 >= LAPS) begin
              state_d = DECEL;
              ivl_d   = sat_add(BASE);
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DECEL: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
          laps_d  = 32'd0;
          ivl_d   = BASE;
        end else if (step) begin
          cnt_d = 32'd0;
          pos_d = pos_nxt;
          ivl_d = sat_add(ivl_q);
          // Entry at pocket 0 is not a step, so target 0 needs a full lap.
          if (pos_nxt == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            laps_d  = 32'd0;
            ivl_d   = BASE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      ivl_q   <= BASE;
      laps_q  <= 32'd0;
      pos_q   <= 6'd0;
      tgt_q   <= 6'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ivl_q   <= ivl_d;
      laps_q  <= laps_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign position = pos_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_roulette_spin_sequencer.sv
// tb_roulette_spin_sequencer: schedule-based reference model plus
// directed and randomized spins.
module tb_roulette_spin_sequencer;

  localparam int NP = 38;
  localparam int BD = 4;
  localparam int DS = 2;
  localparam int MD = 10;
  localparam int ML = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] target = 6'd0;
  logic [5:0] position;
  logic       busy;
  logic       done;
  logic       err;

  roulette_spin_sequencer #(
    .NUM_POS (NP),
    .BASE_DIV(BD),
    .DIV_STEP(DS),
    .MAX_DIV (MD),
    .MIN_LAPS(ML)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .target  (target),
    .abort   (abort),
    .position(position),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int m_pos  = 0;
  bit m_busy = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_n    = 0;
  int m_land = 0;
  int q_t[$];
  int q_p[$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Whole spin as a timetable: (cycle after acceptance, new pocket).
  function automatic void build(input int p0, input int t,
                                output int tq[$], output int pq[$],
                                output int land);
    int tm;
    int p;
    int laps;
    int iv;
    tm = 0;
    p = p0;
    laps = 0;
    tq = {};
    pq = {};
    while (laps < ML) begin
      tm += BD;
      p = (p + 1) % NP;
      if (p == 0) laps++;
      tq.push_back(tm);
      pq.push_back(p);
    end
    iv = imin(BD + DS, MD);
    do begin
      tm += iv;
      p = (p + 1) % NP;
      tq.push_back(tm);
      pq.push_back(p);
      iv = imin(iv + DS, MD);
    end while (p != t);
    land = tm;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_start(input int t);
    @(negedge clock);
    start = 1'b1;
    target = 6'(t);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    bit ok;
    n = 0;
    ok = 0;
    while (n < limit && !ok) begin
      @(posedge clock);
      #2;
      n++;
      if (done) ok = 1;
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_decel();
    int n;
    bit ok;
    n = 0;
    ok = 0;
    while (n < 400 && !ok) begin
      @(posedge clock);
      #2;
      n++;
      if (position != 6'd0) ok = 1;
    end
    ok = 0;
    while (n < 400 && !ok) begin
      @(posedge clock);
      #2;
      n++;
      if (position == 6'd0 && busy) ok = 1;
    end
    if (!ok) chk("decel_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int land;
    int tq[$];
    int pq[$];
    int seq[$];
    int prev;
    int errs;
    int nd;
    int p;

    fork
      forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
          m_pos = 0;
          m_busy = 0;
          m_done = 0;
          m_err = 0;
          m_n = 0;
          q_t = {};
          q_p = {};
        end else begin
          m_done = 0;
          m_err = 0;
          if (m_busy) begin
            m_n++;
            if (abort) begin
              m_busy = 0;
              q_t = {};
              q_p = {};
            end else begin
              while (q_t.size() > 0 && q_t[0] == m_n) begin
                m_pos = q_p[0];
                void'(q_t.pop_front());
                void'(q_p.pop_front());
              end
              if (m_n == m_land) begin
                m_busy = 0;
                m_done = 1;
              end
            end
          end else if (start) begin
            if (int'(target) < NP) begin
              m_busy = 1;
              m_n = 0;
              build(m_pos, int'(target), q_t, q_p, m_land);
            end else begin
              m_err = 1;
            end
          end
        end
      end
      forever begin
        @(posedge clock);
        #2;
        chk("position", int'(position), m_pos);
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
      end
      begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
      end
    join_none

    #12;
    chk("rst_position", int'(position), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clock);
    reset = 1'b1;

    build(0, 5, tq, pq, land);
    chk("model_land_0_5", land, 196);
    build(0, 0, tq, pq, land);
    chk("model_land_0_0", land, 526);
    chk("model_steps_0_0", tq.size(), 76);

    // Normal spin to pocket 5.
    do_start(5);
    chk("t2_busy", int'(busy), 1);
    wait_done(1000, n);
    chk("t2_latency", n, 196);
    chk("t2_pos", int'(position), 5);

    // Out-of-range target.
    do_start(40);
    chk("t3_err", int'(err), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_pos", int'(position), 5);

    // Asynchronous reset in the middle of deceleration.
    do_start(20);
    wait_decel();
    repeat (12) @(posedge clock);
    #3;
    chk("t1_pre_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t1_position", int'(position), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_done", int'(done), 0);
    chk("t1_err", int'(err), 0);
    @(negedge clock);
    reset = 1'b1;

    // Target 0: full decel lap.
    do_start(0);
    seq = {};
    prev = 0;
    n = 0;
    nd = 0;
    while (n < 1000 && nd == 0) begin
      @(posedge clock);
      #2;
      n++;
      if (int'(position) != prev) begin
        seq.push_back(int'(position));
        prev = int'(position);
      end
      if (done) nd = 1;
    end
    chk("t4_done_seen", nd, 1);
    chk("t4_latency", n, 526);
    chk("t4_nsteps", seq.size(), 76);
    errs = 0;
    foreach (seq[i]) if (seq[i] != (i + 1) % NP) errs++;
    chk("t4_seq_errs", errs, 0);
    chk("t4_pos", int'(position), 0);

    // Abort three cycles into deceleration.
    do_start(3);
    wait_decel();
    repeat (3) @(negedge clock);
    p = int'(position);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t5_busy", int'(busy), 0);
    chk("t5_pos", int'(position), p);
    nd = 0;
    repeat (40) begin
      @(posedge clock);
      #2;
      if (done) nd++;
    end
    chk("t5_no_done", nd, 0);
    do_start(7);
    wait_done(1000, n);
    chk("t5_pos7", int'(position), 7);

    // Start while spinning is ignored.
    do_start(12);
    repeat (10) @(negedge clock);
    start = 1'b1;
    target = 6'd9;
    @(negedge clock);
    start = 1'b0;
    chk("t6_busy", int'(busy), 1);
    chk("t6_err", int'(err), 0);
    wait_done(1000, n);
    chk("t6_pos", int'(position), 12);

    // Randomized spins, aborts and stray starts.
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      start = 1'b1;
      target = 6'($urandom_range(0, 45));
      abort = ($urandom_range(0, 3) == 0);
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      for (int c = 0; c < 700; c++) begin
        if (!busy && c > 2) break;
        abort = ($urandom_range(0, 399) == 0);
        start = ($urandom_range(0, 59) == 0);
        target = 6'($urandom_range(0, 63));
        @(negedge clock);
      end
      start = 1'b0;
      abort = 1'b0;
      if (busy) begin
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
      end
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
